arf_datapath: RTL and testbench
===============================

# arf_datapath

Pipelined 32-bit auto-regressive filter (ARF) datapath: 16 constant multiplications and 12 additions, arranged as a 28-node data-flow graph. It produces two filter outputs, node 27 and node 28, from ten input samples. Parameter VARIANCE selects one of two builds:
- the exact build (arf_accurate behaviour);
- an approximate-multiplier build (arf_variance behaviour), used to measure accuracy loss against the exact build.

## Interface
Parameters:
- VARIANCE, 0: 0 = exact multipliers; 1 = truncated (approximate) multipliers.
- TRUNC, 2: number of low operand bits zeroed before each multiply when VARIANCE=1; legal range 0..8.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample strobe; inputs are captured when high.
- in_1_0 .. in_8_0  in  32 each  tap samples, two's complement.
- in_13_1, in_14_1  in  32 each  feedback samples, two's complement.
- out_valid  out  1  high for one cycle when out_27/out_28 are valid.
- out_27, out_28  out  32 each  filter outputs, two's complement.

## Operation
Arithmetic rules:
- All arithmetic is 32-bit two's complement, wrapping modulo 2^32; no saturation.
- Products keep only the low 32 bits.

Fixed coefficients:
- C1..C8 = 3, 5, 7, 9, 11, 13, 2, 6.
- C15..C22 = 13, -3, 5, -7, 2, -1, 4, -6.

Multiply operator mul(x, c):
- VARIANCE=0: x*c.
- VARIANCE=1: (x with its low TRUNC bits forced to 0)*c.
- The coefficient is never truncated.

Data-flow graph:
- m_k = mul(in_k_0, Ck) for k = 1..8.
- n9 = m1+m2; n10 = m3+m4; n11 = m5+m6; n12 = m7+m8.
- n13 = n9 + in_13_1; n14 = n11 + in_14_1.
- m15 = mul(n13,C15); m16 = mul(n13,C16); m17 = mul(n14,C17); m18 = mul(n14,C18).
- m19 = mul(n10,C19); m20 = mul(n10,C20); m21 = mul(n12,C21); m22 = mul(n12,C22).
- n23 = m15+m17; n24 = m16+m18; n25 = m19+m21; n26 = m20+m22.
- out_27 = n23+n25; out_28 = n24+n26.

Both builds must be bit-exact to this graph for their VARIANCE setting. Typical stimulus is 12-bit non-negative samples (0..4095), but the full 32-bit range must be handled.

## Timing
Pipeline registers:
- S1: m1..m8, plus delayed in_13_1 and in_14_1.
- S2: n9..n12, plus delayed in_13_1 and in_14_1.
- S3: n13, n14, n10, n12.
- S4: m15..m22.
- S5: n23..n26.
- S6: out_27, out_28.

Latency and throughput:
- A sample captured at rising edge k appears on out_27/out_28 after edge k+6.
- out_valid is high for the cycle following edge k+6.
- Throughput is one sample per cycle; in_valid may be high every cycle.
- in_valid low: the pipeline still advances, and out_valid is low six edges later. Output data registers hold their last valid value when no valid sample arrives.

Reset:
- rst_n low immediately clears all pipeline registers, out_27, out_28 and out_valid to 0, regardless of clk.
- Samples in flight are discarded.
- The first capture occurs on the first rising edge with rst_n high and in_valid high.

## Test plan
- Reset, then all inputs 0 with in_valid=1 -> out_27=0, out_28=0, out_valid rises exactly 6 edges after capture.
- VARIANCE=0, in_1_0=1, all others 0 -> out_27=39, out_28=-9. Same with in_13_1=10 added -> out_27=169, out_28=-39.
- VARIANCE=0, in_3_0=1 only -> out_27=14, out_28=-7. Check both builds with in_1_0=4 only -> out_27=156, out_28=-36, since no truncation loss occurs.
- VARIANCE=1, TRUNC=2, in_1_0=1 only -> out_27=0, out_28=0; the difference from the exact build is -39 / +9.
- Back-to-back samples on consecutive cycles (alternating 0 and in_1_0=1) -> outputs alternate 0 and 39/-9 with no bubbles. Assert rst_n mid-stream -> outputs and out_valid go to 0 immediately.
- 100 random 12-bit sample sets through both builds against a software golden model -> exact match per build. Also log the out_27/out_28 differences between builds; the exact build's difference from the model is 0.

Source files
------------

// File: rtl/arf_datapath_if.sv
// rtl/arf_datapath_if.sv - sample/result bundle for the ARF datapath
interface arf_datapath_if;
    logic        in_valid;
    logic [31:0] in_1_0;
    logic [31:0] in_2_0;
    logic [31:0] in_3_0;
    logic [31:0] in_4_0;
    logic [31:0] in_5_0;
    logic [31:0] in_6_0;
    logic [31:0] in_7_0;
    logic [31:0] in_8_0;
    logic [31:0] in_13_1;
    logic [31:0] in_14_1;
    logic        out_valid;
    logic [31:0] out_27;
    logic [31:0] out_28;

    modport master (
        output in_valid, in_1_0, in_2_0, in_3_0, in_4_0, in_5_0, in_6_0,
               in_7_0, in_8_0, in_13_1, in_14_1,
        input  out_valid, out_27, out_28
    );

    modport slave (
        input  in_valid, in_1_0, in_2_0, in_3_0, in_4_0, in_5_0, in_6_0,
               in_7_0, in_8_0, in_13_1, in_14_1,
        output out_valid, out_27, out_28
    );
endinterface

// File: rtl/arf_datapath.sv
// rtl/arf_datapath.sv - six-stage pipelined auto-regressive filter datapath
module arf_datapath #(
    parameter int VARIANCE = 0,
    parameter int TRUNC    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    arf_datapath_if.slave bus
);

    // Approximate build zeroes the low TRUNC bits of the data operand only.
    localparam logic [31:0] MASK = (VARIANCE != 0) ? ~((32'd1 << TRUNC) - 32'd1) : '1;

    // Index 0 holds C1 / C15; negative coefficients are 32-bit two's complement.
    localparam logic [7:0][31:0] C_IN  = {32'd6, 32'd2, 32'd13, 32'd11,
                                          32'd9, 32'd7, 32'd5,  32'd3};
    localparam logic [7:0][31:0] C_OUT = {32'hFFFF_FFFA, 32'd4, 32'hFFFF_FFFF, 32'd2,
                                          32'hFFFF_FFF9, 32'd5, 32'hFFFF_FFFD, 32'd13};

    function automatic logic [31:0] mul(input logic [31:0] x, input logic [31:0] c);
        return (x & MASK) * c;
    endfunction

    logic [9:0][31:0] x_q;
    logic [5:0]       vld;
    logic [7:0][31:0] s1_m;
    logic [31:0]      s1_f13, s1_f14;
    logic [3:0][31:0] s2_n;
    logic [31:0]      s2_f13, s2_f14;
    logic [31:0]      s3_n13, s3_n14, s3_n10, s3_n12;
    logic [7:0][31:0] s4_m;
    logic [3:0][31:0] s5_n;
    logic [31:0]      out_27_q, out_28_q;
    logic             out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            vld         <= '0;
            s1_m        <= '0;
            s1_f13      <= '0;
            s1_f14      <= '0;
            s2_n        <= '0;
            s2_f13      <= '0;
            s2_f14      <= '0;
            s3_n13      <= '0;
            s3_n14      <= '0;
            s3_n10      <= '0;
            s3_n12      <= '0;
            s4_m        <= '0;
            s5_n        <= '0;
            out_27_q    <= '0;
            out_28_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                x_q <= {bus.in_14_1, bus.in_13_1, bus.in_8_0, bus.in_7_0, bus.in_6_0,
                        bus.in_5_0, bus.in_4_0, bus.in_3_0, bus.in_2_0, bus.in_1_0};
            end
            vld <= {vld[4:0], bus.in_valid};

            for (int k = 0; k < 8; k++) begin
                s1_m[k] <= mul(x_q[k], C_IN[k]);
            end
            s1_f13 <= x_q[8];
            s1_f14 <= x_q[9];

            for (int k = 0; k < 4; k++) begin
                s2_n[k] <= s1_m[2*k] + s1_m[2*k+1];
            end
            s2_f13 <= s1_f13;
            s2_f14 <= s1_f14;

            s3_n13 <= s2_n[0] + s2_f13;
            s3_n14 <= s2_n[2] + s2_f14;
            s3_n10 <= s2_n[1];
            s3_n12 <= s2_n[3];

            s4_m[0] <= mul(s3_n13, C_OUT[0]);
            s4_m[1] <= mul(s3_n13, C_OUT[1]);
            s4_m[2] <= mul(s3_n14, C_OUT[2]);
            s4_m[3] <= mul(s3_n14, C_OUT[3]);
            s4_m[4] <= mul(s3_n10, C_OUT[4]);
            s4_m[5] <= mul(s3_n10, C_OUT[5]);
            s4_m[6] <= mul(s3_n12, C_OUT[6]);
            s4_m[7] <= mul(s3_n12, C_OUT[7]);

            // n23 = m15+m17, n24 = m16+m18, n25 = m19+m21, n26 = m20+m22
            s5_n[0] <= s4_m[0] + s4_m[2];
            s5_n[1] <= s4_m[1] + s4_m[3];
            s5_n[2] <= s4_m[4] + s4_m[6];
            s5_n[3] <= s4_m[5] + s4_m[7];

            // Output data holds its last valid result across bubbles.
            if (vld[5]) begin
                out_27_q <= s5_n[0] + s5_n[2];
                out_28_q <= s5_n[1] + s5_n[3];
            end
            out_valid_q <= vld[5];
        end
    end

    assign bus.out_27    = out_27_q;
    assign bus.out_28    = out_28_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_arf_datapath.sv
// tb/tb_arf_datapath.sv - directed and random checks of exact and truncated ARF builds
module tb_arf_datapath;

    typedef logic [9:0][31:0] vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   diff_lines = 0;
    vec_t seq[$];
    vec_t v;

    always #5 clk = ~clk;

    arf_datapath_if b0();
    arf_datapath_if b1();

    arf_datapath #(.VARIANCE(0), .TRUNC(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    arf_datapath #(.VARIANCE(1), .TRUNC(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    function automatic logic [31:0] mm(input logic [31:0] x, input logic [31:0] c, input bit ap);
        logic [31:0] xt;
        xt = ap ? (x & 32'hFFFF_FFFC) : x;
        return xt * c;
    endfunction

    function automatic void model(input vec_t s, input bit ap,
                                  output logic [31:0] o27, output logic [31:0] o28);
        logic [31:0] n9, n10, n11, n12, n13, n14;
        n9  = mm(s[0], 32'd3, ap)  + mm(s[1], 32'd5, ap);
        n10 = mm(s[2], 32'd7, ap)  + mm(s[3], 32'd9, ap);
        n11 = mm(s[4], 32'd11, ap) + mm(s[5], 32'd13, ap);
        n12 = mm(s[6], 32'd2, ap)  + mm(s[7], 32'd6, ap);
        n13 = n9 + s[8];
        n14 = n11 + s[9];
        o27 = mm(n13, 32'd13, ap) + mm(n14, 32'd5, ap) + mm(n10, 32'd2, ap) + mm(n12, 32'd4, ap);
        o28 = mm(n13, -32'sd3, ap) + mm(n14, -32'sd7, ap) + mm(n10, -32'sd1, ap) + mm(n12, -32'sd6, ap);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic apply(input vec_t s, input logic vld);
        b0.in_valid = vld;   b1.in_valid = vld;
        b0.in_1_0  = s[0];   b1.in_1_0  = s[0];
        b0.in_2_0  = s[1];   b1.in_2_0  = s[1];
        b0.in_3_0  = s[2];   b1.in_3_0  = s[2];
        b0.in_4_0  = s[3];   b1.in_4_0  = s[3];
        b0.in_5_0  = s[4];   b1.in_5_0  = s[4];
        b0.in_6_0  = s[5];   b1.in_6_0  = s[5];
        b0.in_7_0  = s[6];   b1.in_7_0  = s[6];
        b0.in_8_0  = s[7];   b1.in_8_0  = s[7];
        b0.in_13_1 = s[8];   b1.in_13_1 = s[8];
        b0.in_14_1 = s[9];   b1.in_14_1 = s[9];
    endtask

    // One sample, then idle: checks latency edge, both builds' data, and hold.
    task automatic run_single(input string tag, input vec_t s,
                              input logic [31:0] e27, input logic [31:0] e28,
                              input logic [31:0] a27, input logic [31:0] a28);
        apply(s, 1'b1);
        @(posedge clk); #1;
        apply('0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk({tag, " exact valid before edge 6"}, {31'd0, b0.out_valid}, 32'd0);
        chk({tag, " approx valid before edge 6"}, {31'd0, b1.out_valid}, 32'd0);
        @(posedge clk); #1;
        chk({tag, " exact valid at edge 6"}, {31'd0, b0.out_valid}, 32'd1);
        chk({tag, " approx valid at edge 6"}, {31'd0, b1.out_valid}, 32'd1);
        chk({tag, " exact out_27"}, b0.out_27, e27);
        chk({tag, " exact out_28"}, b0.out_28, e28);
        chk({tag, " approx out_27"}, b1.out_27, a27);
        chk({tag, " approx out_28"}, b1.out_28, a28);
        @(posedge clk); #1;
        chk({tag, " exact valid drops"}, {31'd0, b0.out_valid}, 32'd0);
        chk({tag, " exact out_27 held"}, b0.out_27, e27);
        chk({tag, " approx out_28 held"}, b1.out_28, a28);
    endtask

    // Streams seq back-to-back, one sample per cycle, checking every output cycle.
    task automatic run_stream(input string tag, input bit log_diff);
        logic [31:0] e27, e28, a27, a28;
        int n;
        n = seq.size();
        for (int t = 0; t < n + 6; t++) begin
            if (t < n) apply(seq[t], 1'b1);
            else       apply('0, 1'b0);
            @(posedge clk); #1;
            if (t < 6) begin
                chk({tag, " fill valid"}, {31'd0, b0.out_valid}, 32'd0);
            end else begin
                model(seq[t-6], 1'b0, e27, e28);
                model(seq[t-6], 1'b1, a27, a28);
                chk({tag, " exact valid"}, {31'd0, b0.out_valid}, 32'd1);
                chk({tag, " approx valid"}, {31'd0, b1.out_valid}, 32'd1);
                chk({tag, " exact out_27"}, b0.out_27, e27);
                chk({tag, " exact out_28"}, b0.out_28, e28);
                chk({tag, " approx out_27"}, b1.out_27, a27);
                chk({tag, " approx out_28"}, b1.out_28, a28);
                if (log_diff && diff_lines < 5) begin
                    diff_lines++;
                    $display("%s sample %0d: approx-exact d27=%0d d28=%0d", tag, t - 6,
                             $signed(b1.out_27 - b0.out_27), $signed(b1.out_28 - b0.out_28));
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        apply('0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset exact out_valid", {31'd0, b0.out_valid}, 32'd0);
        chk("reset exact out_27", b0.out_27, 32'd0);
        chk("reset exact out_28", b0.out_28, 32'd0);
        chk("reset approx out_valid", {31'd0, b1.out_valid}, 32'd0);
        rst_n = 1'b1;

        v = '0;
        run_single("zeros", v, 32'd0, 32'd0, 32'd0, 32'd0);

        v = '0; v[0] = 32'd1;
        run_single("in1=1", v, 32'd39, -32'sd9, 32'd0, 32'd0);

        v = '0; v[0] = 32'd1; v[8] = 32'd10;
        run_single("in1=1 in13=10", v, 32'd169, -32'sd39, 32'd104, -32'sd24);

        v = '0; v[2] = 32'd1;
        run_single("in3=1", v, 32'd14, -32'sd7, 32'd0, 32'd0);

        v = '0; v[0] = 32'd4;
        run_single("in1=4", v, 32'd156, -32'sd36, 32'd156, -32'sd36);

        v = '0; v[9] = 32'hFFFF_FFFF;
        run_single("in14=-1", v, -32'sd5, 32'd7, -32'sd20, 32'd28);

        v = '0; v[0] = 32'h8000_0000;
        run_single("in1=min wrap", v, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);

        seq.delete();
        for (int i = 0; i < 8; i++) begin
            v = '0; v[0] = (i % 2 == 1) ? 32'd1 : 32'd0;
            seq.push_back(v);
        end
        run_stream("b2b", 1'b0);
        chk("b2b exact out_27 held", b0.out_27, 32'd39);

        v = '0; v[0] = 32'd1;
        for (int t = 0; t < 7; t++) begin
            apply(v, 1'b1);
            @(posedge clk);
        end
        #1;
        chk("pre-reset exact valid", {31'd0, b0.out_valid}, 32'd1);
        chk("pre-reset exact out_27", b0.out_27, 32'd39);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset exact valid", {31'd0, b0.out_valid}, 32'd0);
        chk("async reset exact out_27", b0.out_27, 32'd0);
        chk("async reset exact out_28", b0.out_28, 32'd0);
        chk("async reset approx valid", {31'd0, b1.out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        apply('0, 1'b0);
        rst_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            chk("flushed valid", {31'd0, b0.out_valid}, 32'd0);
            chk("flushed out_27", b0.out_27, 32'd0);
        end

        seq.delete();
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < 10; k++) v[k] = 32'($urandom_range(4095));
            seq.push_back(v);
        end
        run_stream("random", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
